// File: rtl/trivium_pkg.sv
// trivium_pkg
// Shared definitions for the Trivium keystream generator: register lengths,
// 1-based tap positions of the 288-bit state, the control FSM encoding, the
// default warm-up length and the key/IV load image.
// State vector convention: bit [i-1] of a state_vec_t holds Trivium bit s_i.
package trivium_pkg;

    localparam int LEN_A     = 93;
    localparam int LEN_B     = 84;
    localparam int LEN_C     = 111;
    localparam int STATE_LEN = LEN_A + LEN_B + LEN_C;
    localparam int KEY_LEN   = 80;
    localparam int IV_LEN    = 80;

    // Highest and lowest 1-based bit positions of each shift register
    localparam int A_LO = 1;
    localparam int A_HI = LEN_A;
    localparam int B_LO = LEN_A + 1;
    localparam int B_HI = LEN_A + LEN_B;
    localparam int C_LO = LEN_A + LEN_B + 1;
    localparam int C_HI = STATE_LEN;

    // Tap positions (1-based, as in the cipher description)
    localparam int T1_LIN  = 66;
    localparam int T1_OUT  = 93;
    localparam int T1_ANDA = 91;
    localparam int T1_ANDB = 92;
    localparam int T1_FB   = 171;
    localparam int T2_LIN  = 162;
    localparam int T2_OUT  = 177;
    localparam int T2_ANDA = 175;
    localparam int T2_ANDB = 176;
    localparam int T2_FB   = 264;
    localparam int T3_LIN  = 243;
    localparam int T3_OUT  = 288;
    localparam int T3_ANDA = 286;
    localparam int T3_ANDB = 287;
    localparam int T3_FB   = 69;

    localparam int DEFAULT_INIT_ROUNDS = 1152;

    typedef logic [STATE_LEN-1:0] state_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } fsm_state_t;

    // Key in s1..s80, IV in s94..s173, ones in s286..s288, zeros elsewhere
    function automatic state_vec_t load_image(input logic [KEY_LEN-1:0] key,
                                              input logic [IV_LEN-1:0]  iv);
        state_vec_t s;
        s = '0;
        s[A_LO-1 +: KEY_LEN] = key;
        s[B_LO-1 +: IV_LEN]  = iv;
        s[C_HI-1 -: 3]       = 3'b111;
        return s;
    endfunction

endpackage

// File: rtl/trivium_round.sv
// trivium_round
// One combinational Trivium bit-round.
// Ports:
//   s_in   state before the round (bit [i-1] = s_i)
//   s_out  state after the round
//   z      keystream bit produced by this round
module trivium_round
    import trivium_pkg::*;
(
    input  logic [STATE_LEN-1:0] s_in,
    output logic [STATE_LEN-1:0] s_out,
    output logic                 z
);

    logic t1_lin, t2_lin, t3_lin;
    logic t1_fb, t2_fb, t3_fb;

    assign t1_lin = s_in[T1_LIN-1] ^ s_in[T1_OUT-1];
    assign t2_lin = s_in[T2_LIN-1] ^ s_in[T2_OUT-1];
    assign t3_lin = s_in[T3_LIN-1] ^ s_in[T3_OUT-1];

    assign z = t1_lin ^ t2_lin ^ t3_lin;

    assign t1_fb = t1_lin ^ (s_in[T1_ANDA-1] & s_in[T1_ANDB-1]) ^ s_in[T1_FB-1];
    assign t2_fb = t2_lin ^ (s_in[T2_ANDA-1] & s_in[T2_ANDB-1]) ^ s_in[T2_FB-1];
    assign t3_fb = t3_lin ^ (s_in[T3_ANDA-1] & s_in[T3_ANDB-1]) ^ s_in[T3_FB-1];

    // Each register shifts toward its high end; the feedback of the previous
    // register (cyclically) enters at its lowest position.
    assign s_out = {s_in[C_HI-2:C_LO-1], t2_fb,
                    s_in[B_HI-2:B_LO-1], t1_fb,
                    s_in[A_HI-2:A_LO-1], t3_fb};

endmodule

// File: rtl/trivium_stream.sv
// trivium_stream
// Trivium keystream generator producing W keystream bits per accepted word.
// Parameters:
//   W            bits per word (1,2,4,8,16,32,64)
//   INIT_ROUNDS  warm-up bit-rounds after load (nonzero multiple of W)
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   load         start strobe; key/iv sampled in the same cycle
//   key, iv      80-bit key and IV (bit 0 = K1 / IV1)
//   busy         warm-up in progress
//   ks_valid     keystream word available
//   ks_ready     consumer accepts the word when high with ks_valid
//   ks_data      keystream word, bit 0 = earliest generated bit
module trivium_stream
    import trivium_pkg::*;
#(
    parameter int W           = 64,
    parameter int INIT_ROUNDS = DEFAULT_INIT_ROUNDS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [KEY_LEN-1:0] key,
    input  logic [IV_LEN-1:0]  iv,
    output logic               busy,
    output logic               ks_valid,
    input  logic               ks_ready,
    output logic [W-1:0]       ks_data
);

    localparam int WARM_WORDS = INIT_ROUNDS / W;
    localparam int CNT_MAX    = (WARM_WORDS > 0) ? WARM_WORDS - 1 : 0;
    localparam int CNT_W      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CNT_MAX);

    // Reject illegal parameterisations at elaboration time
    if (!(W == 1 || W == 2 || W == 4 || W == 8 || W == 16 || W == 32 || W == 64)) begin : g_bad_w
        $error("trivium_stream: W must be one of 1,2,4,8,16,32,64");
    end
    if (INIT_ROUNDS <= 0 || (INIT_ROUNDS % W) != 0) begin : g_bad_init
        $error("trivium_stream: INIT_ROUNDS must be a nonzero multiple of W");
    end

    fsm_state_t       state_q, state_d;
    state_vec_t       s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    state_vec_t       chain [0:W];
    logic [W-1:0]     z_vec;

    // W rounds chained in one cycle; round i's z becomes ks_data[i]
    assign chain[0] = s_q;
    for (genvar i = 0; i < W; i++) begin : g_round
        trivium_round u_round (
            .s_in  (chain[i]),
            .s_out (chain[i+1]),
            .z     (z_vec[i])
        );
    end

    // State, counter and FSM registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and outputs. Outputs depend only on the current FSM state,
    // so a load takes effect on ks_valid/busy from the following cycle.
    // Load overrides everything, dropping any word offered this cycle.
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        cnt_d    = cnt_q;
        busy     = 1'b0;
        ks_valid = 1'b0;
        ks_data  = '0;

        case (state_q)
            ST_IDLE: begin
            end
            ST_INIT: begin
                busy = 1'b1;
                s_d  = chain[W];
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RUN: begin
                ks_valid = 1'b1;
                ks_data  = z_vec;
                if (ks_ready) begin
                    s_d = chain[W];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            s_d     = load_image(key, iv);
            cnt_d   = CNT_LOAD;
            state_d = ST_INIT;
        end
    end

endmodule

// File: tb/tb_trivium_stream.sv
// tb_trivium_stream
// Self-checking bench for trivium_stream with three instances (W = 64, 1, 8)
// sharing clk/rst/load/key/iv; sel chooses which instance is observed and
// receives ks_ready. Expected keystream comes from a bit-array model of the
// cipher kept in this file.
module tb_trivium_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [79:0] key;
    logic [79:0] iv;
    logic        ready;
    int          sel;

    logic        busy64, valid64, busy1, valid1, busy8, valid8;
    logic [63:0] data64;
    logic [0:0]  data1;
    logic [7:0]  data8;
    logic        rdy64, rdy1, rdy8;

    logic        cur_busy, cur_valid;
    logic [63:0] cur_data;

    int tests    = 0;
    int failures = 0;

    bit ms [1:288];

    typedef struct {
        int          sel;
        logic [79:0] key;
        logic [79:0] iv;
        int          exp_lat;
        int          nbits;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    assign rdy64 = ready && (sel == 0);
    assign rdy1  = ready && (sel == 1);
    assign rdy8  = ready && (sel == 2);

    trivium_stream #(.W(64)) dut64 (
        .clk(clk), .rst(rst), .load(load), .key(key), .iv(iv),
        .busy(busy64), .ks_valid(valid64), .ks_ready(rdy64), .ks_data(data64)
    );

    trivium_stream #(.W(1)) dut1 (
        .clk(clk), .rst(rst), .load(load), .key(key), .iv(iv),
        .busy(busy1), .ks_valid(valid1), .ks_ready(rdy1), .ks_data(data1)
    );

    trivium_stream #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .load(load), .key(key), .iv(iv),
        .busy(busy8), .ks_valid(valid8), .ks_ready(rdy8), .ks_data(data8)
    );

    always_comb begin
        case (sel)
            0: begin
                cur_busy  = busy64;
                cur_valid = valid64;
                cur_data  = data64;
            end
            1: begin
                cur_busy  = busy1;
                cur_valid = valid1;
                cur_data  = {63'b0, data1};
            end
            default: begin
                cur_busy  = busy8;
                cur_valid = valid8;
                cur_data  = {56'b0, data8};
            end
        endcase
    end

    function automatic int selWidth(input int s);
        if (s == 0) return 64;
        if (s == 1) return 1;
        return 8;
    endfunction

    // Cipher model on a 1-based bit array
    function automatic void modelLoad(input logic [79:0] k, input logic [79:0] v);
        for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            ms[i]      = k[i-1];
            ms[93 + i] = v[i-1];
        end
        ms[286] = 1'b1;
        ms[287] = 1'b1;
        ms[288] = 1'b1;
    endfunction

    function automatic bit modelRound();
        bit t1, t2, t3, z;
        t1 = ms[66]  ^ ms[93];
        t2 = ms[162] ^ ms[177];
        t3 = ms[243] ^ ms[288];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (ms[91]  & ms[92])  ^ ms[171];
        t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
        t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
        for (int i = 93;  i >= 2;   i--) ms[i] = ms[i-1];
        for (int i = 177; i >= 95;  i--) ms[i] = ms[i-1];
        for (int i = 288; i >= 179; i--) ms[i] = ms[i-1];
        ms[1]   = t3;
        ms[94]  = t1;
        ms[178] = t2;
        return z;
    endfunction

    function automatic void modelWarm(input int n);
        for (int i = 0; i < n; i++) void'(modelRound());
    endfunction

    function automatic logic [63:0] modelWord(input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = modelRound();
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst   = 1'b1;
        load  = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called on a negedge; returns on the negedge of the cycle after load
    task automatic applyStimulus(input logic [79:0] k, input logic [79:0] v);
        key  = k;
        iv   = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Starts in cycle load+1; exp_lat is the cycle offset where ks_valid rises
    task automatic runWarmup(input int exp_lat, input string tag);
        int k;
        int busy_cycles;
        bit zero_ok;
        k           = 1;
        busy_cycles = 0;
        zero_ok     = 1'b1;
        while (cur_valid !== 1'b1 && k <= exp_lat + 20) begin
            if (cur_busy === 1'b1) busy_cycles++;
            if (cur_data !== 64'h0) zero_ok = 1'b0;
            @(negedge clk);
            k++;
        end
        checkOutput({tag, " valid latency"}, 64'(k), 64'(exp_lat));
        checkOutput({tag, " busy cycles"}, 64'(busy_cycles), 64'(exp_lat - 1));
        checkOutput({tag, " data zero while invalid"}, 64'(zero_ok), 64'd1);
        checkOutput({tag, " busy low in run"}, 64'(cur_busy), 64'd0);
    endtask

    task automatic collectStream(input int nbits, input string tag);
        int w;
        w     = selWidth(sel);
        ready = 1'b1;
        for (int n = 0; n < nbits / w; n++) begin
            int          guard;
            logic [63:0] e;
            guard = 0;
            while (cur_valid !== 1'b1 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            e = modelWord(w);
            checkOutput($sformatf("%s word %0d", tag, n), cur_data, e);
            @(negedge clk);
        end
        ready = 1'b0;
    endtask

    task automatic checkIdleHold(input int cycles, input string tag);
        bit quiet;
        quiet = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            if (cur_valid !== 1'b0 || cur_busy !== 1'b0 || cur_data !== 64'h0) quiet = 1'b0;
            @(negedge clk);
        end
        checkOutput({tag, " stays idle"}, 64'(quiet), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [79:0] rk, rv;
        logic [63:0] exp_w, prev_data;
        int          accepted, cyc;
        bit          stalled, r;

        rst   = 1'b1;
        load  = 1'b0;
        key   = '0;
        iv    = '0;
        ready = 1'b0;
        sel   = 0;

        rk = 80'({$urandom(), $urandom(), $urandom()});
        rv = 80'({$urandom(), $urandom(), $urandom()});

        vecs[0] = '{0, 80'h0, 80'h0, 19, 512};
        vecs[1] = '{1, 80'h0, 80'h0, 1153, 512};
        vecs[2] = '{2, 80'h0, 80'h0, 145, 512};
        vecs[3] = '{0, {80{1'b1}}, 80'h1, 19, 256};
        vecs[4] = '{2, rk, rv, 145, 256};
        vecs[5] = '{1, {80{1'b1}}, 80'h1, 1153, 64};

        // Reset state, latency and keystream for each table entry
        for (int t = 0; t < 6; t++) begin
            sel = vecs[t].sel;
            doReset();
            checkOutput($sformatf("vec%0d reset busy", t), 64'(cur_busy), 64'd0);
            checkOutput($sformatf("vec%0d reset valid", t), 64'(cur_valid), 64'd0);
            checkOutput($sformatf("vec%0d reset data", t), cur_data, 64'd0);
            modelLoad(vecs[t].key, vecs[t].iv);
            modelWarm(1152);
            applyStimulus(vecs[t].key, vecs[t].iv);
            runWarmup(vecs[t].exp_lat, $sformatf("vec%0d", t));
            collectStream(vecs[t].nbits, $sformatf("vec%0d", t));
        end

        // W=8 with random ready: stalls must hold the word, no loss/duplication
        sel = 2;
        doReset();
        modelLoad(rk, ~rv);
        modelWarm(1152);
        applyStimulus(rk, ~rv);
        runWarmup(145, "stall");
        exp_w     = modelWord(8);
        prev_data = '0;
        accepted  = 0;
        cyc       = 0;
        stalled   = 1'b0;
        while (accepted < 1000 && cyc < 6000) begin
            if (cur_valid !== 1'b1) checkOutput("stall valid", 64'(cur_valid), 64'd1);
            if (stalled) checkOutput($sformatf("stall hold %0d", accepted), cur_data, prev_data);
            checkOutput($sformatf("stall word %0d", accepted), cur_data, exp_w);
            r         = 1'($urandom_range(0, 1));
            ready     = r;
            prev_data = cur_data;
            stalled   = !r;
            @(negedge clk);
            if (r) begin
                accepted++;
                exp_w = modelWord(8);
            end
            cyc++;
        end
        ready = 1'b0;
        checkOutput("stall accepted count", 64'(accepted), 64'd1000);

        // Reload while a word is being accepted at RUN word 10
        sel = 0;
        doReset();
        modelLoad(80'h0, 80'h0);
        modelWarm(1152);
        applyStimulus(80'h0, 80'h0);
        runWarmup(19, "reload first");
        ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            checkOutput($sformatf("reload pre word %0d", n), cur_data, modelWord(64));
            @(negedge clk);
        end
        key  = {80{1'b1}};
        iv   = 80'h1;
        load = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        ready = 1'b0;
        checkOutput("reload valid drop", 64'(cur_valid), 64'd0);
        checkOutput("reload busy", 64'(cur_busy), 64'd1);
        checkOutput("reload data zero", cur_data, 64'd0);
        modelLoad({80{1'b1}}, 80'h1);
        modelWarm(1152);
        runWarmup(19, "reload second");
        collectStream(256, "reload");

        // Reset together with load in INIT cycle 5
        doReset();
        applyStimulus(80'h0, 80'h0);
        repeat (4) @(negedge clk);
        rst  = 1'b1;
        load = 1'b1;
        key  = {80{1'b1}};
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
        checkOutput("rst init busy", 64'(cur_busy), 64'd0);
        checkOutput("rst init valid", 64'(cur_valid), 64'd0);
        checkOutput("rst init data", cur_data, 64'd0);
        checkIdleHold(40, "rst init");

        // Reset during RUN
        applyStimulus(80'h0, 80'h0);
        runWarmup(19, "rst run");
        ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        ready = 1'b0;
        checkOutput("rst run busy", 64'(cur_busy), 64'd0);
        checkOutput("rst run valid", 64'(cur_valid), 64'd0);
        checkOutput("rst run data", cur_data, 64'd0);
        checkIdleHold(40, "rst run");

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
